pipeline_hazard_scheduler: RTL and testbench

- Central stall/flush sequencer for the 5-stage 8-bit pipeline.
- Merges the load-use stall request, taken branches from EX, multi-cycle data-memory waits, interrupts and HALT into one set of pipeline-register enables, flushes and PC-source selects.
- Sits beside the load-use hazard detector and drives the PC, IF/ID, ID/EX and EX/MEM registers.
- Holds the interrupt-holdoff / halt FSM, the memory-timeout counter and a stall performance counter.

---
 rtl/pipeline_hazard_scheduler_pkg.sv | 16 +
 rtl/pipeline_hazard_scheduler_if.sv | 42 ++++
 rtl/pipeline_hazard_scheduler_sat_counter.sv | 21 ++
 rtl/pipeline_hazard_scheduler.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// Imported by the scheduler top and its sub-modules.
package pipeline_hazard_scheduler_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        IRQ_HOLD = 2'b01,
        HALTED   = 2'b10
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_IRQ  = 2'b10;
    localparam logic [1:0] PC_SEL_TRAP = 2'b11;

endpackage

// File: rtl/pipeline_hazard_scheduler_if.sv
// Event inputs and pipeline control outputs of the scheduler.
// master = scheduler side, slave = pipeline side.
interface pipeline_hazard_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             load_use_stall;
    logic             branch_taken_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             irq;
    logic             irq_enable;
    logic             halt_id;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             irq_ack;
    logic             bus_error;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  load_use_stall, branch_taken_ex, mem_req, mem_ready,
        input  irq, irq_enable, halt_id,
        output pc_write, pc_sel, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output irq_ack, bus_error, halted, stall_cycles
    );

    modport slave (
        output load_use_stall, branch_taken_ex, mem_req, mem_ready,
        output irq, irq_enable, halt_id,
        input  pc_write, pc_sel, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  irq_ack, bus_error, halted, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_scheduler_sat_counter.sv
// Saturating up-counter with increment enable.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, hold once every bit is set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Mealy controls from state + events; holdoff/halt FSM inline.
module pipeline_hazard_scheduler
    import pipeline_hazard_scheduler_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int IRQ_HOLDOFF = 4,
    parameter int CNT_W       = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    pipeline_hazard_scheduler_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam int HOLD_W = (IRQ_HOLDOFF > 1) ? $clog2(IRQ_HOLDOFF) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(IRQ_HOLDOFF - 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    logic       freeze, timeout, irq_ok;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic       irq_ack, bus_error, halted;
    logic [1:0] pc_sel;
    logic       stall_inc;

    assign freeze  = bus.mem_req && !bus.mem_ready;
    assign timeout = freeze && (wait_cnt == WAIT_LAST);
    assign irq_ok  = bus.irq && bus.irq_enable && (state != IRQ_HOLD);

    // state, memory-wait and holdoff registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // prioritised event merge into enables, flushes and next state
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        irq_ack      = 1'b0;
        bus_error    = 1'b0;
        halted       = (state == HALTED);
        state_nxt    = state;
        wait_nxt     = '0;
        hold_nxt     = hold_cnt;

        // holdoff only runs down while the pipe is moving
        if ((state == IRQ_HOLD) && !freeze) begin
            if (hold_cnt == '0) begin
                state_nxt = RUN;
            end else begin
                hold_nxt = hold_cnt - 1'b1;
            end
        end

        if (timeout) begin
            bus_error    = 1'b1;
            pc_sel       = PC_SEL_TRAP;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_nxt    = IRQ_HOLD;
            hold_nxt     = HOLD_LOAD;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            wait_nxt     = wait_cnt + 1'b1;
        end else if (irq_ok) begin
            irq_ack     = 1'b1;
            pc_sel      = PC_SEL_IRQ;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = IRQ_HOLD;
            hold_nxt    = HOLD_LOAD;
        end else if (state == HALTED) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.branch_taken_ex) begin
            pc_sel      = PC_SEL_BR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.load_use_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.halt_id && (state == RUN)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = HALTED;
        end

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            pc_sel       = PC_SEL_SEQ;
            irq_ack      = 1'b0;
            bus_error    = 1'b0;
            halted       = 1'b0;
        end
    end

    assign stall_inc = !pc_write && (state != HALTED);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_cycles)
    );

    assign bus.pc_write     = pc_write;
    assign bus.pc_sel       = pc_sel;
    assign bus.if_id_write  = if_id_write;
    assign bus.id_ex_write  = id_ex_write;
    assign bus.ex_mem_write = ex_mem_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.irq_ack      = irq_ack;
    assign bus.bus_error    = bus_error;
    assign bus.halted       = halted;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Directed bench for pipeline_hazard_scheduler.
// Small timeout/holdoff/counter sizes keep the scenarios short.
module tb_pipeline_hazard_scheduler;

    localparam int CNT_W = 4;

    // {pc_write, pc_sel, if_id_w, id_ex_w, ex_mem_w,
    //  if_id_f, id_ex_f, ex_mem_f, irq_ack, bus_error, halted}
    localparam logic [11:0] RST  = 12'b0_00_000_000_000;
    localparam logic [11:0] DEF  = 12'b1_00_111_000_000;
    localparam logic [11:0] LU   = 12'b0_00_011_010_000;
    localparam logic [11:0] BR   = 12'b1_01_111_110_000;
    localparam logic [11:0] FRZ  = 12'b0_00_000_000_000;
    localparam logic [11:0] TRP  = 12'b1_11_111_111_010;
    localparam logic [11:0] IRQ  = 12'b1_10_111_110_100;
    localparam logic [11:0] IRQH = 12'b1_10_111_110_101;
    localparam logic [11:0] HLT  = 12'b0_00_011_010_001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_scheduler_if #(.CNT_W(CNT_W)) hif ();

    pipeline_hazard_scheduler #(
        .MEM_TIMEOUT (4),
        .IRQ_HOLDOFF (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.master)
    );

    function automatic logic [11:0] ctl();
        return {hif.pc_write, hif.pc_sel, hif.if_id_write,
                hif.id_ex_write, hif.ex_mem_write, hif.if_id_flush,
                hif.id_ex_flush, hif.ex_mem_flush, hif.irq_ack,
                hif.bus_error, hif.halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic lu, input logic br,
                          input logic mreq, input logic mrdy,
                          input logic irq, input logic en,
                          input logic halt);
        hif.load_use_stall  = lu;
        hif.branch_taken_ex = br;
        hif.mem_req         = mreq;
        hif.mem_ready       = mrdy;
        hif.irq             = irq;
        hif.irq_enable      = en;
        hif.halt_id         = halt;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_ctl", 32'(ctl()), 32'(RST));
        check("reset_cnt", 32'(hif.stall_cycles), 32'd0);
        rst_n = 1'b1;
        #1 check("run_default", 32'(ctl()), 32'(DEF));

        // load-use then branch over a still-pending load-use
        set_in(1, 0, 0, 0, 0, 0, 0);
        #1 check("load_use", 32'(ctl()), 32'(LU));
        tick();
        set_in(1, 1, 0, 0, 0, 0, 0);
        #1 check("branch_wins", 32'(ctl()), 32'(BR));
        check("cnt_after_lu", 32'(hif.stall_cycles), 32'd1);
        tick();
        check("cnt_after_br", 32'(hif.stall_cycles), 32'd1);

        // three-cycle memory wait
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("mem_freeze", 32'(ctl()), 32'(FRZ));
            tick();
        end
        set_in(0, 0, 1, 1, 0, 0, 0);
        #1 check("mem_done", 32'(ctl()), 32'(DEF));
        tick();
        check("cnt_after_wait", 32'(hif.stall_cycles), 32'd4);

        // timeout on the fourth freeze cycle, then holdoff
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("pre_timeout", 32'(ctl()), 32'(FRZ));
            tick();
        end
        #1 check("timeout", 32'(ctl()), 32'(TRP));
        tick();
        check("cnt_after_to", 32'(hif.stall_cycles), 32'd7);
        set_in(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1 check("holdoff_ign", 32'(ctl()), 32'(DEF));
            tick();
        end
        #1 check("irq_after_hold", 32'(ctl()), 32'(IRQ));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // irq pending across a freeze
        set_in(0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1 check("irq_frozen", 32'(ctl()), 32'(FRZ));
            tick();
        end
        set_in(0, 0, 1, 1, 1, 1, 0);
        #1 check("irq_on_ready", 32'(ctl()), 32'(IRQ));
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1 check("second_irq_hold", 32'(ctl()), 32'(DEF));
            tick();
        end
        #1 check("second_irq", 32'(ctl()), 32'(IRQ));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        check("cnt_after_irq", 32'(hif.stall_cycles), 32'd9);

        // halt, masked irq, then wake
        set_in(0, 0, 0, 0, 0, 0, 1);
        #1 check("halt_entry", 32'(ctl()), 32'(LU));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1 check("halted", 32'(ctl()), 32'(HLT));
        tick();
        tick();
        check("cnt_halted", 32'(hif.stall_cycles), 32'd10);
        set_in(0, 0, 0, 0, 1, 0, 0);
        #1 check("halt_masked", 32'(ctl()), 32'(HLT));
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0);
        #1 check("halt_wake", 32'(ctl()), 32'(IRQH));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1 check("after_wake", 32'(ctl()), 32'(DEF));
        check("cnt_after_wake", 32'(hif.stall_cycles), 32'd10);

        // reset during holdoff and freeze
        set_in(0, 0, 1, 0, 0, 0, 0);
        #1 check("hold_freeze", 32'(ctl()), 32'(FRZ));
        tick();
        rst_n = 1'b0;
        #1 check("mid_reset", 32'(ctl()), 32'(RST));
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 1, 1, 0);
        #1 check("post_reset_irq", 32'(ctl()), 32'(IRQ));
        check("post_reset_cnt", 32'(hif.stall_cycles), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // counter saturation
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (14) tick();
        check("cnt_14", 32'(hif.stall_cycles), 32'd14);
        tick();
        check("cnt_max", 32'(hif.stall_cycles), 32'd15);
        tick();
        check("cnt_sat", 32'(hif.stall_cycles), 32'd15);
        set_in(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
